// File: rtl/mpmc11_resv_table.sv
// Load-reserved / store-conditional reservation table: one reservation per channel,
// granule-address matching, per-entry lifetime timer and round-robin replacement.
module mpmc11_resv_table #(
  parameter int NAR = 4,
  parameter int NCH = 16,
  parameter int AW  = 32,
  parameter int GB  = 5,
  parameter int TMO = 1024,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           op_valid,
  input  logic [1:0]     op,
  input  logic [CHW-1:0] ch,
  input  logic [AW-1:0]  adr,
  output logic           rsp_valid,
  output logic           rb,
  output logic [NAR-1:0] resv_vld
);

  localparam int GRW = AW - GB;
  localparam int TW  = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam int VW  = (NAR > 1) ? $clog2(NAR) : 1;

  typedef enum logic [1:0] {OP_LR = 2'b00, OP_SC = 2'b01, OP_ST = 2'b10, OP_CLR = 2'b11} op_e;

  logic [GRW-1:0] gran;
  assign gran = adr[AW-1:GB];

  generate
    if (GB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^adr[GB-1:0];
    end
  endgenerate

  logic [NAR-1:0] vld_q, vld_d;
  logic [CHW-1:0] ch_q  [NAR];
  logic [CHW-1:0] ch_d  [NAR];
  logic [GRW-1:0] gr_q  [NAR];
  logic [GRW-1:0] gr_d  [NAR];
  logic [TW-1:0]  tmr_q [NAR];
  logic [TW-1:0]  tmr_d [NAR];
  logic [VW-1:0]  vic_q, vic_d;
  logic           rsp_q, rsp_d;
  logic           rb_q, rb_d;

  logic [NAR-1:0] live, ch_m, gr_m;
  logic           hit;
  logic           same_found, free_found;
  logic [VW-1:0]  same_idx, free_idx, lr_idx;
  op_e            op_t;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op_t       = op_e'(op);
    live       = '0;
    ch_m       = '0;
    gr_m       = '0;
    hit        = 1'b0;
    same_found = 1'b0;
    free_found = 1'b0;
    same_idx   = '0;
    free_idx   = '0;
    vld_d      = '0;
    vic_d      = vic_q;

    // An entry whose timer hits zero at this edge is already dead for matching purposes.
    for (int i = 0; i < NAR; i++) begin
      live[i]  = vld_q[i] && !((TMO != 0) && (tmr_q[i] == TW'(1)));
      ch_m[i]  = (ch_q[i] == ch);
      gr_m[i]  = (gr_q[i] == gran);
      hit      = hit | (live[i] && ch_m[i] && gr_m[i]);
      vld_d[i] = live[i];
      ch_d[i]  = ch_q[i];
      gr_d[i]  = gr_q[i];
      tmr_d[i] = ((TMO != 0) && vld_q[i]) ? tmr_q[i] - TW'(1) : tmr_q[i];
    end

    for (int i = NAR - 1; i >= 0; i--) begin
      if (live[i] && ch_m[i]) begin
        same_found = 1'b1;
        same_idx   = VW'(i);
      end
      if (!live[i]) begin
        free_found = 1'b1;
        free_idx   = VW'(i);
      end
    end

    lr_idx = same_found ? same_idx : (free_found ? free_idx : vic_q);

    if (op_valid) begin
      unique case (op_t)
        OP_LR: begin
          for (int i = 0; i < NAR; i++) begin
            if (VW'(i) == lr_idx) begin
              vld_d[i] = 1'b1;
              ch_d[i]  = ch;
              gr_d[i]  = gran;
              tmr_d[i] = TW'(TMO);
            end
          end
          if (!same_found && !free_found)
            vic_d = (vic_q == VW'(NAR - 1)) ? '0 : vic_q + VW'(1);
        end
        OP_SC: begin
          for (int i = 0; i < NAR; i++)
            if (hit ? gr_m[i] : ch_m[i]) vld_d[i] = 1'b0;
        end
        OP_ST: begin
          for (int i = 0; i < NAR; i++)
            if (gr_m[i]) vld_d[i] = 1'b0;
        end
        OP_CLR: begin
          for (int i = 0; i < NAR; i++)
            if (ch_m[i]) vld_d[i] = 1'b0;
        end
        default: ;
      endcase
    end

    rsp_d = op_valid;
    rb_d  = op_valid && (op_t == OP_SC) && hit;
  end

  // NOTE: the table is small flop storage whose reset state is architecturally visible, so every entry is reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      vic_q <= '0;
      rsp_q <= 1'b0;
      rb_q  <= 1'b0;
      for (int i = 0; i < NAR; i++) begin
        ch_q[i]  <= '0;
        gr_q[i]  <= '0;
        tmr_q[i] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
      vld_q <= vld_d;
      vic_q <= vic_d;
      rsp_q <= rsp_d;
      rb_q  <= rb_d;
      for (int i = 0; i < NAR; i++) begin
        ch_q[i]  <= ch_d[i];
        gr_q[i]  <= gr_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  assign rsp_valid = rsp_q;
  assign rb        = rb_q;
  assign resv_vld  = vld_q;

endmodule

// File: tb/tb_mpmc11_resv_table.sv
// Bench for mpmc11_resv_table (NAR=4, TMO=8): a response scoreboard checks every
// cycle's rsp_valid/rb, and each scenario task checks table occupancy inline.
module tb_mpmc11_resv_table;

  localparam logic [1:0] LR = 2'b00, SC = 2'b01, ST = 2'b10, CLR = 2'b11;

  logic        clk = 1'b0;
  logic        rstn;
  logic        op_valid;
  logic [1:0]  op;
  logic [3:0]  ch;
  logic [31:0] adr;
  logic        rsp_valid;
  logic        rb;
  logic [3:0]  resv_vld;

  typedef struct {
    logic rv;
    logic rb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mpmc11_resv_table #(.NAR(4), .NCH(16), .AW(32), .GB(5), .TMO(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .op_valid (op_valid),
    .op       (op),
    .ch       (ch),
    .adr      (adr),
    .rsp_valid(rsp_valid),
    .rb       (rb),
    .resv_vld (resv_vld)
  );

  // Response monitor: each edge out of reset pops the expectation pushed by the driver.
  always begin : mon
    exp_t e;
    @(posedge clk);
    #1;
    if (rstn === 1'b1) begin
      if (sb.size() > 0) e = sb.pop_front();
      else begin
        e.rv = 1'b0;
        e.rb = 1'b0;
      end
      n_cmp++;
      if ({rsp_valid, rb} !== {e.rv, e.rb}) begin
        n_err++;
        $display("FAIL rsp @%0t: got valid=%b rb=%b, want valid=%b rb=%b",
                 $time, rsp_valid, rb, e.rv, e.rb);
      end
    end
  end

  task automatic cycle(input logic v, input logic [1:0] o, input logic [3:0] c,
                       input logic [31:0] a, input logic erb);
    exp_t e;
    @(negedge clk);
    op_valid = v;
    op       = o;
    ch       = c;
    adr      = a;
    e.rv     = v;
    e.rb     = erb;
    sb.push_back(e);
    @(posedge clk);
    #2;
    op_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, LR, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    op_valid = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    op_valid = 1'b1;
    op       = LR;
    ch       = 4'd3;
    adr      = 32'h1000;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rb, resv_vld} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_hold: rsp=%b rb=%b resv_vld=%b, want all 0", rsp_valid, rb, resv_vld);
    end
    op_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    n_cmp++;
    if (resv_vld !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_idle: resv_vld=%b want 0000", resv_vld);
    end
  endtask

  task automatic test_sc_hit();
    do_reset();
    cycle(1'b1, LR, 4'd3, 32'h1000, 1'b0);
    n_cmp++;
    if (resv_vld !== 4'b0001) begin
      n_err++;
      $display("FAIL lr_set: resv_vld=%b want 0001", resv_vld);
    end
    cycle(1'b1, SC, 4'd3, 32'h101C, 1'b1);
    n_cmp++;
    if (resv_vld !== 4'b0000) begin
      n_err++;
      $display("FAIL sc_hit_clear: resv_vld=%b want 0000", resv_vld);
    end
  endtask

  task automatic test_st_kill();
    do_reset();
    cycle(1'b1, LR, 4'd3, 32'h1000, 1'b0);
    cycle(1'b1, ST, 4'd5, 32'h1004, 1'b0);
    n_cmp++;
    if (resv_vld !== 4'b0000) begin
      n_err++;
      $display("FAIL st_kill: resv_vld=%b want 0000", resv_vld);
    end
    cycle(1'b1, SC, 4'd3, 32'h1000, 1'b0);
  endtask

  task automatic test_replace();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, LR, 4'(i), 32'(i * 32'h100), 1'b0);
    n_cmp++;
    if (resv_vld !== 4'b1111) begin
      n_err++;
      $display("FAIL replace_full: resv_vld=%b want 1111", resv_vld);
    end
    cycle(1'b1, SC, 4'd0, 32'h0000, 1'b0);
    n_cmp++;
    if (resv_vld !== 4'b1111) begin
      n_err++;
      $display("FAIL replace_sc_miss: resv_vld=%b want 1111", resv_vld);
    end
    cycle(1'b1, SC, 4'd4, 32'h0400, 1'b1);
    n_cmp++;
    if (resv_vld !== 4'b1110) begin
      n_err++;
      $display("FAIL replace_victim: resv_vld=%b want 1110", resv_vld);
    end
    cycle(1'b1, LR, 4'd5, 32'h0500, 1'b0);
    n_cmp++;
    if (resv_vld !== 4'b1111) begin
      n_err++;
      $display("FAIL replace_refill: resv_vld=%b want 1111", resv_vld);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cycle(1'b1, LR, 4'd1, 32'h40, 1'b0);
    idle(6);
    cycle(1'b1, SC, 4'd1, 32'h40, 1'b1);

    do_reset();
    cycle(1'b1, LR, 4'd1, 32'h40, 1'b0);
    idle(7);
    n_cmp++;
    if (resv_vld !== 4'b0001) begin
      n_err++;
      $display("FAIL tmo_last_cycle: resv_vld=%b want 0001", resv_vld);
    end
    cycle(1'b1, SC, 4'd1, 32'h40, 1'b0);
    n_cmp++;
    if (resv_vld !== 4'b0000) begin
      n_err++;
      $display("FAIL tmo_expired: resv_vld=%b want 0000", resv_vld);
    end

    do_reset();
    cycle(1'b1, LR, 4'd1, 32'h40, 1'b0);
    idle(7);
    cycle(1'b1, LR, 4'd1, 32'h40, 1'b0);
    n_cmp++;
    if (resv_vld !== 4'b0001) begin
      n_err++;
      $display("FAIL tmo_reload: resv_vld=%b want 0001", resv_vld);
    end
    cycle(1'b1, SC, 4'd1, 32'h40, 1'b1);
  endtask

  task automatic test_lr_overwrite();
    do_reset();
    cycle(1'b1, LR, 4'd2, 32'h200, 1'b0);
    cycle(1'b1, LR, 4'd2, 32'h300, 1'b0);
    n_cmp++;
    if (resv_vld !== 4'b0001) begin
      n_err++;
      $display("FAIL lr_overwrite: resv_vld=%b want 0001", resv_vld);
    end
    cycle(1'b1, SC, 4'd2, 32'h300, 1'b1);

    do_reset();
    cycle(1'b1, LR, 4'd2, 32'h200, 1'b0);
    cycle(1'b1, LR, 4'd2, 32'h300, 1'b0);
    cycle(1'b1, SC, 4'd2, 32'h200, 1'b0);
    n_cmp++;
    if (resv_vld !== 4'b0000) begin
      n_err++;
      $display("FAIL sc_miss_clear: resv_vld=%b want 0000", resv_vld);
    end
  endtask

  task automatic test_clr_and_shared();
    do_reset();
    cycle(1'b1, LR,  4'd7, 32'h80,   1'b0);
    cycle(1'b1, LR,  4'd8, 32'h84,   1'b0);
    cycle(1'b1, ST,  4'd9, 32'h2000, 1'b0);
    n_cmp++;
    if (resv_vld !== 4'b0011) begin
      n_err++;
      $display("FAIL st_other_gran: resv_vld=%b want 0011", resv_vld);
    end
    cycle(1'b1, CLR, 4'd7, 32'h0,    1'b0);
    n_cmp++;
    if (resv_vld !== 4'b0010) begin
      n_err++;
      $display("FAIL clr_channel: resv_vld=%b want 0010", resv_vld);
    end
    cycle(1'b1, SC,  4'd8, 32'h80,   1'b1);
    cycle(1'b1, LR,  4'd1, 32'h40,   1'b0);
    cycle(1'b1, LR,  4'd2, 32'h80,   1'b0);
    cycle(1'b1, SC,  4'd1, 32'h80,   1'b0);
    n_cmp++;
    if (resv_vld !== 4'b0010) begin
      n_err++;
      $display("FAIL sc_miss_keep_other: resv_vld=%b want 0010", resv_vld);
    end
    cycle(1'b1, LR,  4'd1, 32'h40,   1'b0);
    cycle(1'b1, LR,  4'd6, 32'h40,   1'b0);
    cycle(1'b1, SC,  4'd6, 32'h5C,   1'b1);
    n_cmp++;
    if (resv_vld !== 4'b0010) begin
      n_err++;
      $display("FAIL sc_hit_all_ch: resv_vld=%b want 0010", resv_vld);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    cycle(1'b1, LR, 4'd3, 32'h1000, 1'b0);
    @(negedge clk);
    op_valid = 1'b1;
    op       = SC;
    ch       = 4'd3;
    adr      = 32'h1000;
    #2;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rb, resv_vld} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_mid_op: rsp=%b rb=%b resv_vld=%b, want all 0", rsp_valid, rb, resv_vld);
    end
    op_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    cycle(1'b1, LR, 4'd3, 32'h1000, 1'b0);
    cycle(1'b1, SC, 4'd3, 32'h1000, 1'b1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    op_valid = 1'b0;
    op       = LR;
    ch       = '0;
    adr      = '0;
    test_reset();
    test_sc_hit();
    test_st_kill();
    test_replace();
    test_timeout();
    test_lr_overwrite();
    test_clr_and_shared();
    test_reset_mid_op();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
